// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - CPU to 16-bit memory bridge splitting 1/2/4/6-byte accesses into halfword beats
module cpu_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rd_wr,
  input  logic [1:0]  cpu_req_sz,
  input  logic [31:0] cpu_addr,
  input  logic [47:0] cpu_wr_data,
  output logic        cpu_enable,
  output logic [47:0] cpu_data_in,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  state_t state, state_next;

  logic          rd_wr;
  logic [2:0]    nbytes;
  logic [31:0]   addr;
  logic [47:0]   wr_data;
  logic [47:0]   asm_data, asm_next;
  logic [1:0]    beat, last_beat;
  logic [CW-1:0] wait_cnt, wait_inc;
  logic          timeout;
  logic [3:0]    span_end, pos0, pos1;
  logic [2:0]    idx0, idx1;
  logic          en0, en1;

  function automatic logic [7:0] pick(input logic [47:0] d, input logic [2:0] i);
    pick = 8'h00;
    for (int j = 0; j < 6; j++)
      if (i == 3'(j)) pick = d[8*j +: 8];
  endfunction

  // Lane positions are byte offsets from the aligned base; idx is the offset into the request.
  always_comb begin
    span_end  = {3'b000, addr[0]} + {1'b0, nbytes};
    last_beat = 2'((span_end - 4'd1) >> 1);
    pos0      = {1'b0, beat, 1'b0};
    pos1      = {1'b0, beat, 1'b1};
    en0       = (pos0 >= {3'b000, addr[0]}) && (pos0 < span_end);
    en1       = (pos1 >= {3'b000, addr[0]}) && (pos1 < span_end);
    idx0      = pos0[2:0] - {2'b00, addr[0]};
    idx1      = pos1[2:0] - {2'b00, addr[0]};
    wait_inc  = wait_cnt + CW'(1);
    timeout   = !mem_ack && (wait_inc == CW'(TIMEOUT_CYCLES));
  end

  always_comb begin
    asm_next = asm_data;
    for (int j = 0; j < 6; j++) begin
      if (en0 && idx0 == 3'(j)) asm_next[8*j +: 8] = mem_rdata[7:0];
      if (en1 && idx1 == 3'(j)) asm_next[8*j +: 8] = mem_rdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req) state_next = BEAT;
      BEAT:    if ((mem_ack && beat == last_beat) || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_enable = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 16'h0;
    mem_be     = 2'b00;
    case (state)
      IDLE: cpu_enable = !cpu_req && !rst;
      BEAT: begin
        mem_req   = 1'b1;
        mem_we    = rd_wr;
        mem_addr  = {addr[31:1], 1'b0} + {29'h0, beat, 1'b0};
        mem_be    = {en1, en0};
        mem_wdata = {en1 ? pick(wr_data, idx1) : 8'h00, en0 ? pick(wr_data, idx0) : 8'h00};
      end
      DONE:    cpu_enable = !rst;
      default: cpu_enable = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wr       <= 1'b0;
      nbytes      <= 3'd0;
      addr        <= 32'h0;
      wr_data     <= 48'h0;
      asm_data    <= 48'h0;
      beat        <= 2'd0;
      wait_cnt    <= '0;
      cpu_data_in <= 48'h0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          rd_wr    <= cpu_rd_wr;
          addr     <= cpu_addr;
          wr_data  <= cpu_wr_data;
          asm_data <= 48'h0;
          beat     <= 2'd0;
          wait_cnt <= '0;
          case (cpu_req_sz)
            2'b00:   nbytes <= 3'd1;
            2'b01:   nbytes <= 3'd2;
            2'b10:   nbytes <= 3'd4;
            default: nbytes <= 3'd6;
          endcase
        end
        BEAT: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (!rd_wr) asm_data <= asm_next;
            if (beat == last_beat) cpu_data_in <= rd_wr ? 48'h0 : asm_next;
            else                   beat <= beat + 2'd1;
          end else if (timeout) begin
            wait_cnt    <= '0;
            cpu_data_in <= {48{1'b1}};
            bus_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb/tb_cpu_mem_bridge.sv - directed and random accesses checked against a byte-level memory model
module tb_cpu_mem_bridge;
  logic        clk = 1'b0;
  logic        rst, cpu_req, cpu_rd_wr;
  logic [1:0]  cpu_req_sz;
  logic [31:0] cpu_addr;
  logic [47:0] cpu_wr_data;
  logic        cpu_enable, bus_err, mem_req, mem_we, mem_ack;
  logic [47:0] cpu_data_in;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;

  int total = 0, passed = 0, failed = 0;
  logic [7:0] mem [logic [31:0]];

  cpu_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_rd_wr(cpu_rd_wr), .cpu_req_sz(cpu_req_sz),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_enable(cpu_enable),
    .cpu_data_in(cpu_data_in), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access: IDLE request cycle, every beat cycle, DONE, and the following IDLE cycle.
  task automatic run_access(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                            input logic [47:0] wd, input int st_lo, input int st_hi, input bit no_ack);
    int n, nb, cycles;
    logic [31:0] base, h, off;
    logic [47:0] exp_data;
    logic [1:0]  exp_be;
    logic [15:0] exp_wd, rd;
    logic        ack;
    n        = (sz == 2'd3) ? 6 : (1 << sz);
    nb       = (int'(a[0]) + n + 1) / 2;
    base     = a & ~32'd1;
    exp_data = '0;

    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b1; cpu_rd_wr = rw; cpu_req_sz = sz; cpu_addr = a; cpu_wr_data = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    #1;
    chk("idle_enable", cpu_enable, 0);
    chk("idle_mem_req", mem_req, 0);

    for (int k = 0; k < nb; k++) begin
      h = base + 32'(2 * k);
      exp_be = 2'b00; exp_wd = 16'h0; rd = 16'h0;
      for (int l = 0; l < 2; l++) begin
        off = h + 32'(l) - a;
        if (off < 32'(n)) begin
          exp_be[l]       = 1'b1;
          exp_wd[8*l +: 8] = wd[8*off +: 8];
          rd[8*l +: 8]     = mem_byte(h + 32'(l));
          if (!rw) exp_data[8*off +: 8] = rd[8*l +: 8];
          else     mem[h + 32'(l)] = wd[8*off +: 8];
        end else begin
          rd[8*l +: 8] = 8'($urandom);
        end
      end
      cycles = no_ack ? 4 : int'($urandom_range(st_hi, st_lo)) + 1;
      for (int w = 0; w < cycles; w++) begin
        ack = !no_ack && (w == cycles - 1);
        @(negedge clk);
        cpu_req = 1'($urandom_range(0, 1)); cpu_rd_wr = 1'($urandom_range(0, 1));
        cpu_req_sz = 2'($urandom); cpu_addr = $urandom; cpu_wr_data = {16'($urandom), $urandom};
        mem_ack = ack; mem_rdata = ack ? rd : 16'($urandom);
        #1;
        chk("beat_mem_req", mem_req, 1);
        chk("beat_enable", cpu_enable, 0);
        chk("beat_addr", mem_addr, h);
        chk("beat_be", mem_be, exp_be);
        chk("beat_we", mem_we, rw);
        chk("beat_wdata", mem_wdata, exp_wd);
      end
      if (no_ack) break;
    end

    if (no_ack) exp_data = {48{1'b1}};
    else if (rw) exp_data = 48'h0;
    @(negedge clk);
    cpu_req = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
    #1;
    chk("done_enable", cpu_enable, 1);
    chk("done_mem_req", mem_req, 0);
    chk("done_bus_err", bus_err, no_ack);
    chk("done_data", cpu_data_in, exp_data);

    @(negedge clk);
    cpu_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("post_enable", cpu_enable, 1);
    chk("post_mem_req", mem_req, 0);
    chk("post_bus_err", bus_err, 0);
    chk("post_hold", cpu_data_in, exp_data);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_rd_wr = 1'b0; cpu_req_sz = 2'b00; cpu_addr = 32'h0;
    cpu_wr_data = 48'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enable", cpu_enable, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_data", cpu_data_in, 0);
    chk("rst_bus_err", bus_err, 0);

    // aligned 32-bit read, request on the first cycle after reset
    mem[32'h100] = 8'hAA; mem[32'h101] = 8'hBB; mem[32'h102] = 8'hCC; mem[32'h103] = 8'hDD;
    run_access(1'b0, 2'b10, 32'h100, 48'h0, 0, 0, 1'b0);
    chk("aligned32_value", cpu_data_in, 48'h0000_DDCC_BBAA);

    run_access(1'b1, 2'b01, 32'h201, 48'h1234, 0, 0, 1'b0);
    run_access(1'b0, 2'b11, 32'h301, 48'h0, 0, 1, 1'b0);
    run_access(1'b0, 2'b00, 32'h55, 48'h0, 3, 3, 1'b0);
    run_access(1'b0, 2'b00, 32'h700, 48'h0, 0, 0, 1'b1);
    run_access(1'b1, 2'b11, 32'hFFFF_FFFD, 48'hA1B2_C3D4_E5F6, 0, 2, 1'b0);
    run_access(1'b0, 2'b11, 32'hFFFF_FFFD, 48'h0, 0, 2, 1'b0);
    chk("wrap_readback", cpu_data_in, 48'hA1B2_C3D4_E5F6);

    // reset during beat 1 of a 4-beat read
    @(negedge clk);
    cpu_req = 1'b1; cpu_rd_wr = 1'b0; cpu_req_sz = 2'b11; cpu_addr = 32'h401; #1;
    @(negedge clk);
    cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111; #1;
    chk("rstbeat_addr0", mem_addr, 32'h400);
    @(negedge clk);
    mem_ack = 1'b0; #1;
    chk("rstbeat_addr1", mem_addr, 32'h402);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstbeat_mem_req", mem_req, 0);
    chk("rstbeat_enable", cpu_enable, 0);
    chk("rstbeat_data", cpu_data_in, 0);
    chk("rstbeat_mem_addr", mem_addr, 0);
    rst = 1'b0; #1;
    chk("rstbeat_idle", cpu_enable, 1);
    chk("rstbeat_no_err", bus_err, 0);
    run_access(1'b0, 2'b11, 32'h401, 48'h0, 0, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = (i % 5 == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : 32'($urandom_range(0, 63));
      run_access(1'($urandom_range(0, 1)), 2'($urandom), ra, {16'($urandom), $urandom}, 0, 3, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
